fp_div_iter: RTL

- Parametrised, multi-cycle IEEE-754 floating-point divider: one restoring quotient bit per cycle, round-to-nearest-even, exception flags.
- Has a valid/ready handshake and a tag that passes through unchanged, so the FPU can issue divides out of the pipelined lanes and retire them asynchronously.
- Single operation in flight.
- Defaults give binary32.

---
 rtl/fp_div_iter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative IEEE-754 divider, one restoring quotient bit per cycle,
// round-to-nearest-even, flush-to-zero on subnormal inputs and outputs.
// One operation in flight at a time. The tag is returned unchanged with the result.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts any operation in flight)
//   in_valid   operands and tag valid
//   in_ready   divider idle, can accept
//   op0 / op1  dividend / divisor, IEEE format
//   in_tag     issue tag
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   res        quotient, IEEE format
//   out_tag    tag captured at accept
//   flags      {invalid, div_by_zero, overflow, underflow, inexact}
module fp_div_iter #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int TAG_WIDTH  = 6,
    localparam int DATA_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] op0,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] res,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [4:0]            flags
);

    localparam int QW = MANT_WIDTH + 3;      // quotient: integer, fraction, guard, round
    localparam int RW = MANT_WIDTH + 2;      // remainder holds up to 2*divisor
    localparam int XW = EXP_WIDTH + 2;       // signed working exponent
    localparam int CW = $clog2(QW + 1);
    localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_WIDTH) - 1);
    localparam logic signed [XW-1:0] ONE_X   = XW'(1);
    localparam logic signed [XW-1:0] ZERO_X  = '0;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV, S_ROUND, S_DONE} state_t;

    state_t                  r_state, w_next;
    logic [DATA_WIDTH-1:0]   r_op0, r_op1;
    logic [TAG_WIDTH-1:0]    r_tag;
    logic                    r_sign;
    logic signed [XW-1:0]    r_exp;
    logic [RW-1:0]           r_rem, r_dvs;
    logic [QW-1:0]           r_quo;
    logic [CW-1:0]           r_cnt;
    logic [DATA_WIDTH-1:0]   r_res;
    logic [TAG_WIDTH-1:0]    r_out_tag;
    logic [4:0]              r_flags;

    // Normalise, round to nearest even on guard/round/sticky, then range-check.
    // Returns {result, flags}.
    function automatic logic [DATA_WIDTH+4:0] round_rne(
        input logic                 sign,
        input logic signed [XW-1:0] exp_in,
        input logic [QW-1:0]        quo,
        input logic                 sticky
    );
        logic [QW-1:0]         q;
        logic signed [XW-1:0]  e;
        logic [MANT_WIDTH:0]   mant;
        logic [MANT_WIDTH+1:0] sum;
        logic                  g, r, up;
        q = quo;
        e = exp_in;
        // Quotient of two [1,2) mantissas lies in (0.5,2): at most one shift.
        // After the shift the round bit is unknown, but only round|sticky matters.
        if (!q[QW-1]) begin
            q = {q[QW-2:0], 1'b0};
            e = e - ONE_X;
        end
        mant = q[QW-1:2];
        g    = q[1];
        r    = q[0];
        up   = g & (r | sticky | mant[0]);
        sum  = {1'b0, mant} + {{(MANT_WIDTH+1){1'b0}}, up};
        if (sum[MANT_WIDTH+1]) begin
            e    = e + ONE_X;
            mant = sum[MANT_WIDTH+1:1];
        end else begin
            mant = sum[MANT_WIDTH:0];
        end
        if (e >= EXP_MAX)
            return {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}, 5'b00101};
        else if (e <= ZERO_X)
            return {sign, {(DATA_WIDTH-1){1'b0}}, 5'b00011};
        else
            return {sign, e[EXP_WIDTH-1:0], mant[MANT_WIDTH-1:0], 4'b0000, g | r | sticky};
    endfunction

    // Operand classification; operands stay registered until the result is loaded.
    logic [EXP_WIDTH-1:0]  w_e0, w_e1;
    logic [MANT_WIDTH-1:0] w_m0, w_m1;
    logic                  w_zero0, w_zero1, w_inf0, w_inf1, w_nan0, w_nan1;
    logic                  w_sign, w_special;
    logic [DATA_WIDTH-1:0] w_spec_res;
    logic [4:0]            w_spec_flags;

    assign w_e0    = r_op0[DATA_WIDTH-2 -: EXP_WIDTH];
    assign w_e1    = r_op1[DATA_WIDTH-2 -: EXP_WIDTH];
    assign w_m0    = r_op0[MANT_WIDTH-1:0];
    assign w_m1    = r_op1[MANT_WIDTH-1:0];
    assign w_zero0 = (w_e0 == '0);
    assign w_zero1 = (w_e1 == '0);
    assign w_inf0  = (w_e0 == '1) && (w_m0 == '0);
    assign w_inf1  = (w_e1 == '1) && (w_m1 == '0);
    assign w_nan0  = (w_e0 == '1) && (w_m0 != '0);
    assign w_nan1  = (w_e1 == '1) && (w_m1 != '0);
    assign w_sign  = r_op0[DATA_WIDTH-1] ^ r_op1[DATA_WIDTH-1];
    assign w_special = w_zero0 | w_zero1 | w_inf0 | w_inf1 | w_nan0 | w_nan1;

    always_comb begin
        w_spec_res   = '0;
        w_spec_flags = '0;
        if (w_nan0 || w_nan1 || (w_zero0 && w_zero1) || (w_inf0 && w_inf1)) begin
            w_spec_res   = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
            w_spec_flags = 5'b10000;
        end else if (w_inf0) begin
            w_spec_res = {w_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        end else if (w_inf1) begin
            w_spec_res = {w_sign, {(DATA_WIDTH-1){1'b0}}};
        end else if (w_zero1) begin
            w_spec_res   = {w_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            w_spec_flags = 5'b01000;
        end else begin
            w_spec_res = {w_sign, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    // Restoring step: subtract when it fits, shift remainder left.
    logic                  w_ge;
    logic [RW-1:0]         w_diff;
    logic [DATA_WIDTH+4:0] w_rnd;

    assign w_ge   = (r_rem >= r_dvs);
    assign w_diff = w_ge ? (r_rem - r_dvs) : r_rem;
    assign w_rnd  = round_rne(r_sign, r_exp, r_quo, |r_rem);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Special cases also pass through ROUND so the result register loads in one place.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_CHECK;
            S_CHECK: w_next = w_special ? S_ROUND : S_DIV;
            S_DIV:   if (r_cnt == CW'(QW - 1)) w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: if (in_valid) begin
                r_op0 <= op0;
                r_op1 <= op1;
                r_tag <= in_tag;
            end
            S_CHECK: begin
                r_sign <= w_sign;
                r_exp  <= $signed({2'b00, w_e0}) - $signed({2'b00, w_e1}) + BIAS;
                r_rem  <= {1'b0, 1'b1, w_m0};
                r_dvs  <= {1'b0, 1'b1, w_m1};
                r_quo  <= '0;
                r_cnt  <= '0;
            end
            S_DIV: begin
                r_quo <= {r_quo[QW-2:0], w_ge};
                r_rem <= {w_diff[RW-2:0], 1'b0};
                r_cnt <= r_cnt + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res     <= '0;
            r_flags   <= '0;
            r_out_tag <= '0;
        end else if (r_state == S_ROUND) begin
            r_res     <= w_special ? w_spec_res   : w_rnd[DATA_WIDTH+4:5];
            r_flags   <= w_special ? w_spec_flags : w_rnd[4:0];
            r_out_tag <= r_tag;
        end else if (r_state == S_DONE && out_ready) begin
            r_res     <= '0;
            r_flags   <= '0;
            r_out_tag <= '0;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign res       = r_res;
    assign out_tag   = r_out_tag;
    assign flags     = r_flags;

endmodule
